// File: rtl/mem_responder_ram.sv
// mem_responder_ram: serves one address window of the CPU mem_* bus from
// word-organised on-chip RAM, with programmable wait states.
// Optional feature: define MEM_RESP_SEQ_EN to give sequential accesses
// (same width and direction, next address) SEQ_WAIT_CYCLES instead of
// WAIT_CYCLES.
//
// state   | meaning
// IDLE    | no access in flight; a window hit is accepted here
// WAIT    | access accepted, counting down wait cycles
// ACK     | single-cycle acknowledge; read data on mem_data
module mem_responder_ram #(
  parameter logic [31:0] BASE_ADDR       = 32'h0300_0000,
  parameter int          ADDR_BITS       = 15,
  parameter int          WAIT_CYCLES     = 1,
  parameter int          SEQ_WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  input  logic [1:0]  mem_width,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_ok
);

  localparam int WORDS = 2 ** (ADDR_BITS - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [1:0]             width_q, width_d;
  logic                   dir_q, dir_d;
  logic [31:0]            rdata_q;
  logic                   mem_ok_q;
  logic [31:0]            ram_q [WORDS];

  logic                   req, hit, enter_ack, ram_we;
  logic [1:0]             width_n;
  logic [3:0]             wait_load;
  logic [31:0]            rd_word, rd_fmt, wr_data;
  logic [3:0]             wr_be;

  assign req     = mem_read || mem_write;
  assign hit     = (mem_addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]) && req;
  assign width_n = (mem_width == 2'd3) ? 2'd2 : mem_width;

`ifdef MEM_RESP_SEQ_EN
  logic [ADDR_BITS-1:0] last_addr_q;
  logic [1:0]           last_width_q;
  logic                 last_dir_q;
  logic                 last_vld_q;
  logic [ADDR_BITS:0]   step, next_addr;
  logic                 seq_hit;

  // Sequential detect; the extra top bit catches a step past the window top.
  always_comb begin
    step = (ADDR_BITS+1)'(1);
    case (width_n)
      2'd0:    step = (ADDR_BITS+1)'(1);
      2'd1:    step = (ADDR_BITS+1)'(2);
      default: step = (ADDR_BITS+1)'(4);
    endcase
    next_addr = {1'b0, last_addr_q} + step;
    seq_hit   = last_vld_q && !next_addr[ADDR_BITS]
                && (next_addr[ADDR_BITS-1:0] == mem_addr[ADDR_BITS-1:0])
                && (width_n == last_width_q) && (mem_write == last_dir_q);
    wait_load = seq_hit ? 4'(SEQ_WAIT_CYCLES) : 4'(WAIT_CYCLES);
  end

  // Remember the last acknowledged access; drop it on any gap or withdrawal.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_addr_q  <= '0;
      last_width_q <= 2'd0;
      last_dir_q   <= 1'b0;
      last_vld_q   <= 1'b0;
    end else if (state_q == ST_ACK) begin
      last_addr_q  <= addr_q;
      last_width_q <= width_q;
      last_dir_q   <= dir_q;
      last_vld_q   <= 1'b1;
    end else if ((state_q == ST_IDLE && !hit) || (state_q == ST_WAIT && !req)) begin
      last_vld_q   <= 1'b0;
    end
  end
`else
  assign wait_load = 4'(WAIT_CYCLES);
`endif

  // Next-state logic: accept in IDLE, count in WAIT, one-cycle ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    width_d = width_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          addr_d  = mem_addr[ADDR_BITS-1:0];
          width_d = width_n;
          dir_d   = mem_write;
          cnt_d   = wait_load;
          state_d = (wait_load != 4'd0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!req) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Access is committed on the edge that enters ACK, from the values being latched.
  assign enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
  assign ram_we    = rstn && enter_ack && dir_d;

  // Lane steering for reads and byte enables for writes.
  always_comb begin
    rd_word = ram_q[addr_d[ADDR_BITS-1:2]];
    rd_fmt  = rd_word;
    wr_data = mem_data;
    wr_be   = 4'b1111;
    case (width_d)
      2'd0: begin
        rd_fmt  = {24'h0, rd_word[{addr_d[1:0], 3'b000} +: 8]};
        wr_data = {4{mem_data[7:0]}};
        wr_be   = 4'b0001 << addr_d[1:0];
      end
      2'd1: begin
        rd_fmt  = addr_d[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
        wr_data = {2{mem_data[15:0]}};
        wr_be   = addr_d[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        case (addr_d[1:0])
          2'd0: rd_fmt = rd_word;
          2'd1: rd_fmt = {rd_word[7:0],  rd_word[31:8]};
          2'd2: rd_fmt = {rd_word[15:0], rd_word[31:16]};
          default: rd_fmt = {rd_word[23:0], rd_word[31:24]};
        endcase
      end
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) ram_q[addr_d[ADDR_BITS-1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      width_q  <= 2'd0;
      dir_q    <= 1'b0;
      rdata_q  <= 32'h0;
      mem_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      width_q  <= width_d;
      dir_q    <= dir_d;
      mem_ok_q <= (state_d == ST_ACK);
      if (enter_ack && !dir_d) rdata_q <= rd_fmt;
    end
  end

  assign mem_ok   = mem_ok_q;
  assign mem_data = (state_q == ST_ACK && !dir_q) ? rdata_q : 32'bz;

endmodule

// File: tb/tb_mem_responder_ram.sv
// Bench for mem_responder_ram: directed scenarios followed by random accesses
// checked against a byte-array model of the window.
module tb_mem_responder_ram;

  localparam logic [31:0] BASE = 32'h0300_0000;
`ifdef MEM_RESP_SEQ_EN
  localparam int  TB_WAIT   = 2;
  localparam bit  TB_SEQ_EN = 1'b1;
`else
  localparam int  TB_WAIT   = 1;
  localparam bit  TB_SEQ_EN = 1'b0;
`endif
  localparam int  TB_SEQ    = 0;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic [1:0]  width;
  logic        rd, wr;
  logic        drv_en;
  logic [31:0] drv_val;
  wire  [31:0] mem_data;
  logic        mem_ok;

  assign mem_data = drv_en ? drv_val : 32'bz;
  always #5 clk = ~clk;

  mem_responder_ram #(
    .BASE_ADDR(BASE), .ADDR_BITS(15), .WAIT_CYCLES(TB_WAIT), .SEQ_WAIT_CYCLES(TB_SEQ)
  ) dut (
    .clk(clk), .rstn(rstn), .mem_addr(addr), .mem_data(mem_data), .mem_width(width),
    .mem_read(rd), .mem_write(wr), .mem_ok(mem_ok)
  );

  logic [7:0] mdl [0:63];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         last_vld, chained, last_dir;
  int         last_off;
  int         last_w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input int off, input logic [1:0] w);
    logic [31:0] word;
    int b, h, sh;
    b = off & ~3;
    h = off & ~1;
    word = {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
    sh = 8 * (off % 4);
    if (w == 2'd0) return {24'h0, mdl[off]};
    if (w == 2'd1) return {16'h0, mdl[h+1], mdl[h]};
    return (word >> sh) | (word << (32 - sh));
  endfunction

  function automatic void mdl_write(input int off, input logic [1:0] w, input logic [31:0] d);
    int b;
    if (w == 2'd0) mdl[off] = d[7:0];
    else if (w == 2'd1) begin
      b = off & ~1;
      mdl[b] = d[7:0]; mdl[b+1] = d[15:8];
    end else begin
      b = off & ~3;
      mdl[b] = d[7:0]; mdl[b+1] = d[15:8]; mdl[b+2] = d[23:16]; mdl[b+3] = d[31:24];
    end
  endfunction

  function automatic int exp_wait(input int off, input logic [1:0] w, input bit is_wr);
    int wn;
    wn = (w == 2'd3) ? 2 : int'(w);
    if (TB_SEQ_EN && last_vld && off == last_off + (1 << wn) && wn == last_w && is_wr == last_dir)
      return TB_SEQ;
    return TB_WAIT;
  endfunction

  // One access starting at a negedge; keep=1 chains the next access into the IDLE cycle after ACK.
  task automatic do_access(input int off, input logic [1:0] w, input bit is_wr,
                           input logic [31:0] wd, input bit keep, input string tag);
    int cnt, ew;
    logic [31:0] exp_rd;
    ew = exp_wait(off, w, is_wr);
    exp_rd = mdl_read(off, w);
    addr = BASE + 32'(off); width = w; rd = !is_wr; wr = is_wr; drv_en = is_wr; drv_val = wd;
    cnt = 0;
    do begin
      @(posedge clk); @(negedge clk); cnt++;
    end while (!mem_ok && cnt < 64);
    check({tag, " latency"}, 32'(chained ? cnt - 1 : cnt), 32'(ew + 1));
    if (mem_ok) begin
      if (is_wr) mdl_write(off, w, wd);
      else check({tag, " rdata"}, mem_data, exp_rd);
    end
    last_off = off; last_w = (w == 2'd3) ? 2 : int'(w); last_dir = is_wr; last_vld = 1'b1;
    if (keep) chained = 1'b1;
    else begin
      rd = 1'b0; wr = 1'b0; drv_en = 1'b0;
      @(negedge clk);
      check({tag, " ack single"}, 32'(mem_ok), 32'd0);
      @(negedge clk);
      chained = 1'b0; last_vld = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int off, cnt;
    logic [1:0] w;
    bit is_wr, keep;
    rd = 1'b0; wr = 1'b0; addr = '0; width = 2'd0;
    drv_en = 1'b1; drv_val = 32'h5A5A_0F0F;
    rstn = 1'b0; last_vld = 1'b0; chained = 1'b0; last_off = 0; last_w = 0; last_dir = 1'b0;
    repeat (3) @(negedge clk);
    check("reset mem_ok", 32'(mem_ok), 32'd0);
    check("reset bus released", mem_data, 32'h5A5A_0F0F);
    rstn = 1'b1; drv_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      do_access(i * 4, 2'd2, 1'b1, $urandom, 1'($urandom_range(0, 1)), "init");
    if (chained) begin
      do_access(0, 2'd2, 1'b0, 32'h0, 1'b0, "init tail");
    end

    do_access(32'h10, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, "t1 wr");
    do_access(32'h10, 2'd2, 1'b0, 32'h0, 1'b0, "t1 rd");
    do_access(32'h10, 2'd2, 1'b1, 32'h1122_3344, 1'b0, "t2 wr word");
    do_access(32'h13, 2'd0, 1'b1, 32'h0000_00A5, 1'b0, "t2 wr byte");
    do_access(32'h10, 2'd2, 1'b0, 32'h0, 1'b0, "t2 rd word");
    do_access(32'h12, 2'd0, 1'b0, 32'h0, 1'b0, "t2 rd byte");
    do_access(32'h11, 2'd2, 1'b0, 32'h0, 1'b0, "t3 rd unaligned");
    do_access(32'h13, 2'd1, 1'b0, 32'h0, 1'b0, "t3 rd half");

    addr = 32'h0200_0000; width = 2'd2; rd = 1'b1; drv_en = 1'b1; drv_val = 32'h0F0F_5A5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4 miss mem_ok", 32'(mem_ok), 32'd0);
      check("t4 miss bus", mem_data, 32'h0F0F_5A5A);
    end
    rd = 1'b0; drv_en = 1'b0;
    repeat (2) @(negedge clk);

    addr = BASE + 32'h10; width = 2'd2; wr = 1'b1; drv_en = 1'b1; drv_val = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    wr = 1'b0; drv_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5 withdraw mem_ok", 32'(mem_ok), 32'd0);
    end
    do_access(32'h10, 2'd2, 1'b0, 32'h0, 1'b0, "t5 rd after withdraw");

    addr = BASE + 32'h14; width = 2'd2; wr = 1'b1; drv_en = 1'b1; drv_val = 32'h0BAD_F00D;
    @(posedge clk); @(negedge clk);
    rstn = 1'b0;
    #1;
    check("t5 reset in wait mem_ok", 32'(mem_ok), 32'd0);
    wr = 1'b0; drv_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5 idle after reset", 32'(mem_ok), 32'd0);
    end
    do_access(32'h14, 2'd2, 1'b0, 32'h0, 1'b0, "t5 rd after reset");

    addr = BASE + 32'h18; width = 2'd2; rd = 1'b1;
    cnt = 0;
    do begin @(posedge clk); @(negedge clk); cnt++; end while (!mem_ok && cnt < 64);
    check("t5 ack before reset", 32'(mem_ok), 32'd1);
    rstn = 1'b0;
    #1;
    check("t5 reset in ack mem_ok", 32'(mem_ok), 32'd0);
    rd = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    do_access(32'h00, 2'd2, 1'b0, 32'h0, 1'b1, "t6 rd 00");
    do_access(32'h04, 2'd2, 1'b0, 32'h0, 1'b1, "t6 rd 04");
    do_access(32'h0C, 2'd2, 1'b0, 32'h0, 1'b0, "t6 rd 0C");

    for (int i = 0; i < 150; i++) begin
      if (chained && $urandom_range(0, 1) == 1) begin
        w = 2'(last_w); is_wr = last_dir;
        off = (last_off + (1 << last_w)) & 63;
      end else begin
        w = 2'($urandom_range(0, 3)); is_wr = 1'($urandom_range(0, 1));
        off = $urandom_range(0, 63);
      end
      keep = (i == 149) ? 1'b0 : 1'($urandom_range(0, 1));
      do_access(off, w, is_wr, $urandom, keep, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
